// File: rtl/stream_pacer_pkg.sv
// stream_pacer_pkg: shared FSM state type and level-width helper for the stream pacer.
`default_nettype none

package stream_pacer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_pacer_if.sv
// stream_pacer_if: upstream valid/ready word stream feeding the pacer FIFO.
`default_nettype none

interface stream_pacer_if #(
  parameter int WIDTH = 8
) ();

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

`default_nettype wire

// File: rtl/pacer_fifo.sv
// pacer_fifo: synchronous FIFO with push/pop/flush; extra pointer bit separates full from empty.
`default_nettype none

module pacer_fifo
  import stream_pacer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  input  logic [WIDTH-1:0]              wdata_i,
  output logic [WIDTH-1:0]              rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [level_width(DEPTH)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i  && !empty_o) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: occupancy is governed entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !flush_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_pacer.sv
// stream_pacer: buffers upstream words and releases one every period_i cycles as an enable/data strobe.
`default_nettype none

module stream_pacer
  import stream_pacer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int PERIOD_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          run_i,
  input  logic                          flush_i,
  input  logic [PERIOD_WIDTH-1:0]       period_i,
  stream_pacer_if.slave                 s_if,
  output logic                          enable_o,
  output logic [WIDTH-1:0]              data_o,
  output logic                          underrun_o,
  output logic [level_width(DEPTH)-1:0] level_o
);

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] period_m1;
  logic                    enable_q, enable_d;
  logic                    underrun_q, underrun_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic                    rdy_q;
  logic                    tick;
  logic                    pop;
  logic                    push;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [WIDTH-1:0]        fifo_rdata;

  // A zero period behaves as a one-cycle period.
  assign period_m1 = (period_i == '0) ? '0 : period_i - 1'b1;

  assign s_if.s_ready = rdy_q && !fifo_full;
  assign push         = s_if.s_valid && s_if.s_ready && !flush_i;

  pacer_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .wdata_i (s_if.s_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enable_d   = 1'b0;
    underrun_d = 1'b0;
    data_d     = data_q;
    tick       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) begin
          state_d = ST_RUN;
          cnt_d   = period_m1;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          tick  = 1'b1;
          cnt_d = period_m1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (!run_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush swallows the tick: no strobe and no underrun that cycle.
    if (tick && !flush_i) begin
      if (!fifo_empty) begin
        pop      = 1'b1;
        enable_d = 1'b1;
        data_d   = fifo_rdata;
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      enable_q   <= 1'b0;
      underrun_q <= 1'b0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enable_q   <= enable_d;
      underrun_q <= underrun_d;
      data_q     <= data_d;
      rdy_q      <= 1'b1;
    end
  end

  assign enable_o   = enable_q;
  assign underrun_o = underrun_q;
  assign data_o     = data_q;

endmodule

`default_nettype wire
